// File: rtl/gear_shift_scheduler.sv
// Gear shift scheduler: arbitrates brake, manual buttons and an auto speed policy into one-clk shift pulses.
// Define SHIFT_REJECT_EN to add reject_o, a one-clk pulse when a manual request is dropped at a gear limit.
module gear_shift_scheduler #(
  parameter int NUM_GEARS   = 5,
  parameter int STEP        = 40,
  parameter int HYST        = 8,
  parameter int DWELL_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_auto,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       brake,
  input  logic [7:0] speed,
  output logic       shift_up_o,
  output logic       shift_down_o,
  output logic [2:0] gear,
  output logic       busy
`ifdef SHIFT_REJECT_EN
  ,
  output logic       reject_o
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT_UP, SHIFT_DN, DWELL} state_t;

  localparam int               CNT_W      = (DWELL_TICKS < 1) ? 1 : $clog2(DWELL_TICKS + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_TICKS);
  localparam logic [2:0]       TOP_GEAR   = 3'(NUM_GEARS);
  localparam logic [8:0]       STEP_9     = 9'(STEP);
  localparam logic [8:0]       HYST_9     = 9'(HYST);

  state_t           state, state_next;
  logic             btn_up_q, btn_down_q;
  logic             pend_up, pend_down;
  logic [CNT_W-1:0] dwell_cnt;
  logic             up_edge, down_edge;
  logic             svc_up, svc_dn, rej_up, rej_dn;
  logic [8:0]       gear_9, speed_9, up_thr, dn_base, dn_thr;
  logic             up_req, dn_req;

  assign up_edge   = btn_up & ~btn_up_q;
  assign down_edge = btn_down & ~btn_down_q;

  // Thresholds in 9 bits so gear*STEP cannot wrap past the 8-bit speed range.
  assign gear_9  = {6'd0, gear};
  assign speed_9 = {1'b0, speed};
  assign up_thr  = gear_9 * STEP_9;
  assign dn_base = (gear_9 - 9'd1) * STEP_9;
  assign dn_thr  = (dn_base >= HYST_9) ? (dn_base - HYST_9) : 9'd0;

  assign up_req = mode_auto && (gear != 3'd0) && (gear < TOP_GEAR) && (speed_9 >= up_thr);
  assign dn_req = mode_auto && (gear > 3'd1) && (speed_9 < dn_thr);

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    svc_up     = 1'b0;
    svc_dn     = 1'b0;
    rej_up     = 1'b0;
    rej_dn     = 1'b0;
    case (state)
      IDLE: begin
        if (brake && (gear > 3'd1)) begin
          state_next = SHIFT_DN;
        end else if (pend_down) begin
          if (gear != 3'd0) begin
            state_next = SHIFT_DN;
            svc_dn     = 1'b1;
          end else begin
            rej_dn = 1'b1;
          end
        end else if (pend_up) begin
          if (gear < TOP_GEAR) begin
            state_next = SHIFT_UP;
            svc_up     = 1'b1;
          end else begin
            rej_up = 1'b1;
          end
        end else if (dn_req) begin
          state_next = SHIFT_DN;
        end else if (up_req) begin
          state_next = SHIFT_UP;
        end
      end
      SHIFT_UP, SHIFT_DN: state_next = DWELL;
      DWELL:              if (dwell_cnt == '0) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift_up_o   <= 1'b0;
      shift_down_o <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      shift_up_o   <= (state_next == SHIFT_UP);
      shift_down_o <= (state_next == SHIFT_DN);
      busy         <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gear      <= 3'd0;
      dwell_cnt <= '0;
    end else begin
      case (state)
        SHIFT_UP: begin
          gear      <= gear + 3'd1;
          dwell_cnt <= DWELL_LOAD;
        end
        SHIFT_DN: begin
          gear      <= gear - 3'd1;
          dwell_cnt <= DWELL_LOAD;
        end
        DWELL: if (tick && (dwell_cnt != '0)) dwell_cnt <= dwell_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // A fresh edge in the servicing cycle re-arms the flag rather than being lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
      pend_up    <= 1'b0;
      pend_down  <= 1'b0;
    end else begin
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      pend_up    <= (pend_up & ~(svc_up | rej_up)) | up_edge;
      pend_down  <= (pend_down & ~(svc_dn | rej_dn)) | down_edge;
    end
  end

`ifdef SHIFT_REJECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) reject_o <= 1'b0;
    else       reject_o <= rej_up | rej_dn;
  end
`endif

endmodule

// File: tb/tb_gear_shift_scheduler.sv
// Scoreboard bench for gear_shift_scheduler: stimulus queues expected shift events, a monitor pops them.
// Build with +define+SHIFT_REJECT_EN to also score reject_o pulses.
module tb_gear_shift_scheduler;

  localparam int DWELL_TICKS = 4;
  localparam int DRAIN_LIMIT = 400;
  localparam logic [1:0] EV_UP = 2'd0, EV_DN = 2'd1, EV_REJ = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] gear;
  } ev_t;

  logic       clk, reset, tick, mode_auto, btn_up, btn_down, brake;
  logic [7:0] speed;
  logic       shift_up_o, shift_down_o, busy;
  logic [2:0] gear;
`ifdef SHIFT_REJECT_EN
  logic       reject_o;
`endif

  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  tick_phase = 0;

  gear_shift_scheduler #(
    .NUM_GEARS(5), .STEP(40), .HYST(8), .DWELL_TICKS(DWELL_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .mode_auto(mode_auto),
    .btn_up(btn_up), .btn_down(btn_down), .brake(brake), .speed(speed),
    .shift_up_o(shift_up_o), .shift_down_o(shift_down_o), .gear(gear), .busy(busy)
`ifdef SHIFT_REJECT_EN
    , .reject_o(reject_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick every fourth clock, driven mid-cycle.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick = (tick_phase == 3);
      tick_phase = (tick_phase + 1) % 4;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic push(input logic [1:0] kind, input logic [2:0] g);
    exp_q.push_back('{kind: kind, gear: g});
  endtask

  task automatic score_event(input logic [1:0] kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d at gear %0d, expected none", kind, gear);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(kind), int'(e.kind));
      check("event_gear", int'(gear), int'(e.gear));
    end
  endtask

  // Monitor: scores pulses, forbids back-to-back/overlapping pulses, counts ticks spent in DWELL.
  initial begin
    logic pulse, prev_pulse, prev_busy;
    int   dwell_ticks;
    prev_pulse  = 1'b0;
    prev_busy   = 1'b0;
    dwell_ticks = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_pulse  = 1'b0;
        prev_busy   = 1'b0;
        dwell_ticks = 0;
      end else begin
        pulse = shift_up_o | shift_down_o;
        if (shift_up_o && shift_down_o) check("both_pulses", 1, 0);
        if (prev_pulse && pulse) check("back_to_back_pulse", 1, 0);
        if (pulse) score_event(shift_up_o ? EV_UP : EV_DN);
`ifdef SHIFT_REJECT_EN
        if (reject_o) score_event(EV_REJ);
`endif
        if (busy && !pulse && tick) dwell_ticks++;
        if (prev_busy && !busy) begin
          check("dwell_ticks", dwell_ticks, DWELL_TICKS);
          dwell_ticks = 0;
        end
        prev_busy  = busy;
        prev_pulse = pulse;
      end
    end
  end

  task automatic press_up();
    @(negedge clk) btn_up = 1'b1;
    @(negedge clk) btn_up = 1'b0;
  endtask

  task automatic press_down();
    @(negedge clk) btn_down = 1'b1;
    @(negedge clk) btn_down = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < DRAIN_LIMIT);
    check("drain_in_time", int'(n < DRAIN_LIMIT), 1);
  endtask

  initial begin
    reset = 1'b1; mode_auto = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    brake = 1'b0; speed = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_gear", int'(gear), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_up", int'(shift_up_o), 0);
    check("reset_down", int'(shift_down_o), 0);
    reset = 1'b0;

    // Manual up from neutral; monitor checks the full 4-tick dwell.
    push(EV_UP, 3'd0);
    press_up();
    wait_done();
    check("manual_up_gear", int'(gear), 1);

    // Auto: 40 at gear 1 shifts up, 40 at gear 2 holds, 31 < 32 shifts down.
    push(EV_UP, 3'd1);
    @(negedge clk) begin mode_auto = 1'b1; speed = 8'd40; end
    wait_done();
    check("auto_up_gear", int'(gear), 2);
    repeat (30) @(negedge clk);
    check("auto_hold_gear", int'(gear), 2);
    push(EV_DN, 3'd2);
    speed = 8'd31;
    wait_done();
    check("auto_down_gear", int'(gear), 1);
    mode_auto = 1'b0;
    speed = 8'd0;

    // Climb to 4, then brake with a held manual up request.
    push(EV_UP, 3'd1); press_up(); wait_done();
    push(EV_UP, 3'd2); press_up(); wait_done();
    push(EV_UP, 3'd3); press_up(); wait_done();
    check("climb_gear", int'(gear), 4);
    push(EV_DN, 3'd4); push(EV_DN, 3'd3); push(EV_DN, 3'd2);
    push(EV_UP, 3'd1); push(EV_DN, 3'd2);
    @(negedge clk) begin brake = 1'b1; speed = 8'd200; btn_up = 1'b1; end
    @(negedge clk) btn_up = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);
    check("brake_floor_gear", int'(gear), 1);
    brake = 1'b0;
    speed = 8'd0;

    // Simultaneous up and down edges at gear 2: down first, up after dwell.
    push(EV_UP, 3'd1); press_up(); wait_done();
    push(EV_DN, 3'd2); push(EV_UP, 3'd1);
    @(negedge clk) begin btn_up = 1'b1; btn_down = 1'b1; end
    @(negedge clk) begin btn_up = 1'b0; btn_down = 1'b0; end
    wait_done();
    check("both_edges_gear", int'(gear), 2);

    // Two extra up edges during dwell collapse into one shift.
    push(EV_UP, 3'd2); push(EV_UP, 3'd3);
    press_up();
    repeat (3) @(negedge clk);
    press_up();
    press_up();
    wait_done();
    check("absorbed_edges_gear", int'(gear), 4);

    // Up request at top gear is dropped.
    push(EV_UP, 3'd4); press_up(); wait_done();
`ifdef SHIFT_REJECT_EN
    push(EV_REJ, 3'd5);
`endif
    press_up();
    repeat (10) @(negedge clk);
    check("top_gear_hold", int'(gear), 5);

    // Reset during SHIFT_DN aborts the pulse immediately.
    @(negedge clk) btn_down = 1'b1;
    @(negedge clk) btn_down = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (shift_down_o) break;
    end
    check("dn_pulse_seen", int'(shift_down_o), 1);
    reset = 1'b1;
    #1;
    check("abort_down", int'(shift_down_o), 0);
    check("abort_gear", int'(gear), 0);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_gear", int'(gear), 0);

    // Down request in neutral is dropped.
`ifdef SHIFT_REJECT_EN
    push(EV_REJ, 3'd0);
`endif
    press_down();
    repeat (10) @(negedge clk);
    check("neutral_down_gear", int'(gear), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gear_shift_scheduler.md
Name: gear_shift_scheduler

Overview:
Sequences the gearbox FSM: arbitrates manual shift buttons, brake and an automatic speed-based policy. Issues one-clock shift_up/shift_down command pulses and tracks the engaged gear. Enforces a minimum dwell between shifts so the gearbox never sees back-to-back commands. Runs on the fast system clock; the dwell timer advances only on a tick enable from the clock divider.

Parameters:
NUM_GEARS, 5, highest forward gear (gear 0 = neutral, 1..NUM_GEARS forward)
STEP, 40, speed units per gear band for auto thresholds
HYST, 8, downshift hysteresis in speed units (must be < STEP)
DWELL_TICKS, 4, tick pulses spent in DWELL after every shift

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk enable pulse from the clock divider
mode_auto  input  1  1 = automatic policy enabled; manual requests still honoured
btn_up  input  1  manual up request, level, synchronised upstream
btn_down  input  1  manual down request, level, synchronised upstream
brake  input  1  brake pedal, level
speed  input  8  unsigned vehicle speed
shift_up_o  output  1  one-clk up command to gearbox FSM
shift_down_o  output  1  one-clk down command to gearbox FSM
gear  output  3  engaged gear, 0..NUM_GEARS
busy  output  1  high in SHIFT_UP, SHIFT_DN, DWELL

Behaviour:
- Reset (async, active-high): state IDLE, gear=0, shift_up_o=0, shift_down_o=0, busy=0, dwell counter=0, pending flags=0, button history regs=0.
- Buttons are rising-edge detected against a registered copy. Each edge sets pend_up / pend_down, one-deep; repeated edges while pending are absorbed. A pend_* flag clears in the cycle it is serviced or rejected.
- Auto thresholds, computed in 9-bit unsigned arithmetic: up_req when mode_auto && 1<=gear<NUM_GEARS && speed >= gear*STEP. dn_req when mode_auto && gear>1 && speed < (gear-1)*STEP - HYST, clamped at 0. No auto shift from or into neutral.
- IDLE arbitration, evaluated each clk, fixed priority:
  1. brake && gear>1 -> SHIFT_DN
  2. pend_down -> SHIFT_DN if gear>0, else reject
  3. pend_up -> SHIFT_UP if gear<NUM_GEARS, else reject
  4. dn_req -> SHIFT_DN
  5. up_req -> SHIFT_UP
- Brake never shifts below gear 1. Manual down from gear 1 engages neutral.
- When pend_up and pend_down are set together, down wins and pend_up stays pending.
- While brake is high and gear>1, pend_up is held, not rejected.
- SHIFT_UP / SHIFT_DN last exactly one clk. The matching output is 1 only in this state, registered, so it asserts one clk after the IDLE decision. gear increments or decrements on the edge leaving the state. Next state is DWELL with the counter loaded with DWELL_TICKS.
- DWELL: counter decrements on tick. Return to IDLE when counter==0 is observed, so DWELL_TICKS=0 gives a one-clk DWELL. Button edges during SHIFT/DWELL are latched into pend_*; nothing else is acted on.
- Shift pulses never assert in consecutive clks. shift_up_o and shift_down_o are never high together.
- Reset asserted mid-shift or mid-dwell aborts immediately to the reset values; no pulse completes.

Optional Feature:
SHIFT_REJECT_EN
- Defined: adds output reject_o (1 bit). It pulses for one clk, registered, whenever a pending manual request is dropped: pend_up at gear==NUM_GEARS, or pend_down at gear==0. Reset value 0.
- Undefined: the port is absent and rejected requests are silently cleared. All other behaviour is identical.

Test Plan:
- Reset; pulse btn_up once, DWELL_TICKS=4, tick every 4 clks -> shift_up_o high exactly 1 clk, gear 0->1, busy held until 4 ticks have elapsed.
- mode_auto=1, gear=1, speed=40 -> single up pulse, gear=2. Hold speed=40 -> no further shift (needs 80). Drop speed to 31 -> down pulse, gear=1 (threshold 40-8=32).
- gear=4, brake held, speed=200 -> three down pulses, each separated by a full dwell. gear ends at 1 and stays at 1 while brake is held.
- btn_up and btn_down edges in the same clk at gear=2 -> down serviced first (gear=1), then up serviced after dwell (gear=2).
- Two btn_up edges during DWELL -> exactly one extra up shift after dwell.
- gear=NUM_GEARS, btn_up edge -> no pulse, gear unchanged. With SHIFT_REJECT_EN defined, reject_o pulses 1 clk.
- Assert reset during SHIFT_DN -> shift_down_o=0, gear=0 the same cycle.
